// File: rtl/syndrome_checker_pkg.sv
// Shared definitions for the syndrome checker.
//   - K_N_DEFAULT : default codeword word width
//   - MASK_F0..F3 : the four parity-check mask rows (256 bits each)
//   - MASK_ROWS   : the rows packed so that MASK_ROWS[a] is row a
//   - state_t     : FSM state encoding
package syndrome_checker_pkg;

    localparam int K_N_DEFAULT = 256;
    localparam int MASK_W      = 256;

    localparam logic [MASK_W-1:0] MASK_F0 =
        256'h3808686AD4706057D160CE6DD1FBDC49BC2C9D9D15C639207F397CCCB46CD901;
    localparam logic [MASK_W-1:0] MASK_F1 =
        256'h75DCFBBD645F404EEA309F6104F99C058C59D4E975A24DE11CC5A3079B559A92;
    localparam logic [MASK_W-1:0] MASK_F2 =
        256'h6709C0EB57ECCD19C6C16A91FB816854314972D239BC37824D749BFB3A13ABA5;
    localparam logic [MASK_W-1:0] MASK_F3 =
        256'hF657015660A9458EF3551EF7B7AD4AB1669250F9716DCD8669F5E8D2743414DA;

    localparam logic [3:0][MASK_W-1:0] MASK_ROWS = {MASK_F3, MASK_F2, MASK_F1, MASK_F0};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CHECK = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/parity_mask_rom.sv
// Combinational lookup of one parity-check mask row.
//   adrs [1:0]   : row select (0..3)
//   row  [K_N-1:0]: selected mask row, resized to the word width
module parity_mask_rom
    import syndrome_checker_pkg::*;
#(
    parameter int K_N = K_N_DEFAULT
) (
    input  logic [1:0]     adrs,
    output logic [K_N-1:0] row
);

    always_comb begin
        row = K_N'(MASK_ROWS[adrs]);
    end

endmodule

// File: rtl/syndrome_checker.sv
// Frame syndrome checker. Each accepted word is checked against the four mask
// rows over four cycles; the row used for syndrome bit r is rotated by the
// word index. After the last word of a frame the 4-bit syndrome is offered
// on a valid/ready output.
//   clk, rst_n   : clock, asynchronous active-low reset
//   flush        : synchronous abort of the current frame
//   in_data/in_valid/in_ready       : word input handshake
//   out_syndrome/out_error/out_valid/out_ready : result handshake
module syndrome_checker
    import syndrome_checker_pkg::*;
#(
    parameter int K_N       = K_N_DEFAULT,
    parameter int NUM_WORDS = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           flush,
    input  logic [K_N-1:0] in_data,
    input  logic           in_valid,
    output logic           in_ready,
    output logic [3:0]     out_syndrome,
    output logic           out_error,
    output logic           out_valid,
    input  logic           out_ready
);

    localparam int WIDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam logic [WIDX_W-1:0] LAST_WIDX = WIDX_W'(NUM_WORDS - 1);

    state_t            state_q, state_d;
    logic [1:0]        row_q, row_d;
    logic [WIDX_W-1:0] widx_q, widx_d;
    logic [K_N-1:0]    word_q, word_d;
    logic [3:0]        syn_q, syn_d;

    logic [1:0]        mask_adrs;
    logic [K_N-1:0]    mask_row;
    logic              word_parity;

    // Row rotation: (row + widx) mod 4 falls out of the 2-bit add.
    assign mask_adrs = row_q + 2'(widx_q);

    parity_mask_rom #(
        .K_N (K_N)
    ) u_rom (
        .adrs (mask_adrs),
        .row  (mask_row)
    );

    assign word_parity = ^(word_q & mask_row);

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        widx_d  = widx_q;
        word_d  = word_q;
        syn_d   = syn_q;

        if (flush) begin
            // Flush wins over both handshakes; a same-cycle in_valid is dropped.
            state_d = ST_IDLE;
            row_d   = '0;
            widx_d  = '0;
            syn_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        word_d  = in_data;
                        row_d   = '0;
                        state_d = ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    syn_d[row_q] = syn_q[row_q] ^ word_parity;
                    row_d        = row_q + 2'd1;
                    if (row_q == 2'd3) begin
                        if (widx_q == LAST_WIDX) begin
                            state_d = ST_DONE;
                        end else begin
                            widx_d  = widx_q + 1'b1;
                            state_d = ST_IDLE;
                        end
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        syn_d   = '0;
                        widx_d  = '0;
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            row_q   <= '0;
            widx_q  <= '0;
            word_q  <= '0;
            syn_q   <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            widx_q  <= widx_d;
            word_q  <= word_d;
            syn_q   <= syn_d;
        end
    end

    // Syndrome is only visible while the result is offered.
    assign in_ready     = (state_q == ST_IDLE);
    assign out_valid    = (state_q == ST_DONE);
    assign out_syndrome = out_valid ? syn_q : 4'd0;
    assign out_error    = |out_syndrome;

endmodule
